// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and memory-side bus bundle for the shared
//               memory port arbiter. The slave modport is the arbiter's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    // fetch side
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic [DATA_W-1:0] o_if_rdata;

    // load/store side
    logic              i_ls_req;
    logic              i_ls_wen;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [DATA_W-1:0] i_ls_wdata;
    logic [MASK_W-1:0] i_ls_mask;
    logic              o_ls_gnt;
    logic              o_ls_rvalid;
    logic [DATA_W-1:0] o_ls_rdata;

    // memory side
    logic              o_mem_req;
    logic              o_mem_wen;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [MASK_W-1:0] o_mem_mask;
    logic              i_mem_ready;
    logic              i_mem_rvalid;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_busy;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_mask,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_busy
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_mask,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between fetch and load/store, one
//               outstanding transaction at a time. Define MEM_ARB_RR_EN for
//               round-robin arbitration; default is load/store priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0] mem_mask_q, mem_mask_d;
    logic              owner_ls_q, owner_ls_d;

    logic              w_pick_ls;
    logic              w_if_gnt;
    logic              w_ls_gnt;
    logic              w_if_rvalid;
    logic              w_ls_rvalid;

`ifdef MEM_ARB_RR_EN
    // Pointer resets to "fetch" so the first contention goes to load/store.
    logic last_ls_q, last_ls_d;

    assign w_pick_ls = bus.i_ls_req && !(bus.i_if_req && last_ls_q);
    assign last_ls_d = (w_if_gnt || w_ls_gnt) ? w_ls_gnt : last_ls_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_ls_q <= 1'b0;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end
`else
    assign w_pick_ls = bus.i_ls_req;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mask_d  = mem_mask_q;
        owner_ls_d  = owner_ls_q;
        w_if_gnt    = 1'b0;
        w_ls_gnt    = 1'b0;
        w_if_rvalid = 1'b0;
        w_ls_rvalid = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Reset gates the grant so no requester sees an accept that is discarded.
                if (i_rst_n && (bus.i_ls_req || bus.i_if_req)) begin
                    w_ls_gnt   = w_pick_ls;
                    w_if_gnt   = !w_pick_ls;
                    owner_ls_d = w_pick_ls;
                    mem_req_d  = 1'b1;
                    state_d    = S_ISSUE;
                    if (w_pick_ls) begin
                        mem_wen_d   = bus.i_ls_wen;
                        mem_addr_d  = bus.i_ls_addr;
                        mem_wdata_d = bus.i_ls_wdata;
                        mem_mask_d  = bus.i_ls_mask;
                    end else begin
                        mem_wen_d   = 1'b0;
                        mem_addr_d  = bus.i_if_addr;
                        mem_wdata_d = '0;
                        mem_mask_d  = '1;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.i_mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_wen_q ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (i_rst_n && bus.i_mem_rvalid) begin
                    w_if_rvalid = !owner_ls_q;
                    w_ls_rvalid = owner_ls_q;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            owner_ls_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mask_q  <= mem_mask_d;
            owner_ls_q  <= owner_ls_d;
        end
    end

    assign bus.o_if_gnt    = w_if_gnt;
    assign bus.o_ls_gnt    = w_ls_gnt;
    assign bus.o_if_rvalid = w_if_rvalid;
    assign bus.o_ls_rvalid = w_ls_rvalid;
    assign bus.o_if_rdata  = bus.i_mem_rdata;
    assign bus.o_ls_rdata  = bus.i_mem_rdata;
    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_wen   = mem_wen_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_mask  = mem_mask_q;
    assign bus.o_busy      = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single shared memory port between instruction fetch and the load/store path of the RV32I core, one outstanding transaction at a time. Load/store requests carry the `mem_read`/`mem_write` intent and the byte mask produced by the control decoder. The block presents a registered request/ready/rvalid bus to memory and routes each read response back to the requester that owns it. It sits between the fetch stage, the memory stage and the unified memory model.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; the mask is DATA_W/8 bits

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_if_req  in  1  fetch requests a read; i_if_addr is held stable until granted
- i_if_addr  in  ADDR_W  fetch address
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  o_if_rdata is valid this cycle
- o_if_rdata  out  DATA_W  fetch read data
- i_ls_req  in  1  load/store request; all i_ls_* held stable until granted
- i_ls_wen  in  1  1 = store, 0 = load
- i_ls_addr  in  ADDR_W  load/store address
- i_ls_wdata  in  DATA_W  store data
- i_ls_mask  in  DATA_W/8  byte mask: 0001, 0011 or 1111
- o_ls_gnt  out  1  load/store request accepted this cycle
- o_ls_rvalid  out  1  load data valid this cycle; never asserted for stores
- o_ls_rdata  out  DATA_W  load data
- o_mem_req  out  1  request to memory, registered
- o_mem_wen  out  1  registered write enable
- o_mem_addr  out  ADDR_W  registered address
- o_mem_wdata  out  DATA_W  registered write data
- o_mem_mask  out  DATA_W/8  registered byte mask; all ones for fetch
- i_mem_ready  in  1  memory accepts the request this cycle
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  DATA_W  read data
- o_busy  out  1  a transaction is in flight (state not IDLE)

## Operation

States:
- IDLE: no transaction in flight.
- ISSUE: request presented to memory, waiting for i_mem_ready.
- RESP: read issued, waiting for i_mem_rvalid.

Transitions:
- IDLE: if any i_*_req is high, select a winner (see Configuration). Assert that winner's gnt combinationally in the same cycle. Latch the winner's address, wdata, mask and wen into the o_mem_* registers, record the owner, and go to ISSUE.
- ISSUE: hold o_mem_req and the payload until i_mem_ready. On ready, a store goes to IDLE; a load or fetch goes to RESP.
- RESP: on i_mem_rvalid, raise the owner's rvalid for exactly that cycle and go to IDLE.

Data routing and outputs:
- o_if_rdata and o_ls_rdata are both driven from i_mem_rdata; only the owner's rvalid qualifies the data.
- gnt is never asserted outside IDLE. Requests raised while busy wait, with payload held, until the next IDLE cycle.
- o_mem_req is 0 in IDLE and RESP.

Ignored inputs and boundary cases:
- i_mem_rvalid in IDLE or ISSUE is ignored; no rvalid output is produced.
- i_mem_ready outside ISSUE is ignored.
- Both requests high in IDLE: exactly one gnt is asserted. The loser stays pending.
- Request dropped before grant: legal, no side effects.
- Reset: the synchronous reset takes effect at any state, including mid-transaction. State goes to IDLE. The outstanding response is abandoned, and a late i_mem_rvalid is ignored because the block is in IDLE.

## Timing

- Reset values: o_mem_req 0, o_mem_wen 0, o_mem_addr 0, o_mem_wdata 0, o_mem_mask 0, o_if_gnt 0, o_ls_gnt 0, o_if_rvalid 0, o_ls_rvalid 0, o_busy 0. The last-grant pointer resets to "fetch".
- Request in cycle N (IDLE) gives gnt in N and o_mem_req high from N+1.
- Zero-wait memory (ready in N+1, rvalid in N+2):
  - read: rvalid out in N+2, IDLE in N+3
  - store: IDLE in N+2
- Back-to-back throughput: one store per 2 cycles; one read per 3 cycles.
- Each i_mem_rvalid asserted in RESP produces exactly one single-cycle rvalid pulse.

## Configuration

- MEM_ARB_RR_EN defined: round-robin. On contention, the requester not granted last wins, and the last-grant pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, load/store always wins. The pointer logic is removed, so fetch can starve under continuous load/store traffic.
- Under both settings the first contention after reset goes to load/store.

## Test plan

- Single fetch, addr 0x0000_0010, zero-wait memory returning 0x0051_3023: o_if_gnt in cycle 0, o_mem_req/o_mem_addr=0x10/mask 1111 in cycle 1, o_if_rvalid with 0x0051_3023 in cycle 2, o_ls_rvalid stays 0.
- Store sb: addr 0x0000_0103, wdata 0xAB, mask 0001, i_mem_ready delayed 3 cycles: o_mem_req held 3 cycles with stable payload, then IDLE. No rvalid on either side.
- Both requesters high continuously for 8 grants:
  - MEM_ARB_RR_EN: grants alternate ls, if, ls, if…
  - macro undefined: all 8 grants go to ls and o_if_gnt stays 0.
- Spurious i_mem_rvalid in IDLE and in ISSUE: no rvalid outputs and no state change. A later genuine rvalid in RESP is delivered once.
- i_rst_n low for one cycle while in RESP: all outputs 0 and state IDLE next cycle. The following i_mem_rvalid is ignored, and a new fetch is granted normally.
